fir_mac_sched: RTL

FIR_MAC_SCHED -- requirements
Module: fir_mac_sched

---
 rtl/fir_mac_sched.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/fir_mac_sched.sv
// ---------------------------------------------------------------------------
// fir_mac_sched
// Control sequencer for a two-channel FIR filter sharing one MAC. A requesting
// channel is granted round-robin, its sample is shifted in (ack), the MAC is
// cleared, NTAPS taps are accumulated, the pipeline drains for DRAIN cycles and
// a one-cycle out_valid marks the finished sum for out_ch.
//
// Parameters:
//   NTAPS  taps per output sample (2..31)
//   DRAIN  MAC pipeline depth in cycles (>= 1)
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-low reset
//   req[1:0]   per-channel sample-ready request
//   ack[1:0]   one-hot single-cycle grant (registered)
//   ch_sel     channel currently owning the MAC
//   tap_addr   tap index for the data/coefficient muxes
//   mac_en     accumulate enable (registered)
//   acc_clr    accumulator/multiplier clear (registered)
//   out_valid  final-sum strobe (registered)
//   out_ch     channel tag for out_valid
//   busy       high in every state except IDLE
//
// Optional feature, enabled by defining SCHED_STATS_EN:
//   stat_clr   synchronous clear of busy_cnt (wins over increment)
//   busy_cnt   saturating count of busy cycles
//
// tap_addr returns to 0 in DONE, so it is already 0 for the following IDLE.
// ---------------------------------------------------------------------------
module fir_mac_sched #(
  parameter int NTAPS = 21,
  parameter int DRAIN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  output logic [1:0]  ack,
  output logic        ch_sel,
  output logic [4:0]  tap_addr,
  output logic        mac_en,
  output logic        acc_clr,
  output logic        out_valid,
  output logic        out_ch,
  output logic        busy
`ifdef SCHED_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [15:0] busy_cnt
`endif
);

  localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [4:0]    TAP_LAST   = 5'(NTAPS - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, FLUSH, DONE} state_t;

  state_t          state_q, state_d;
  logic            ch_sel_q, ch_sel_d;
  logic            last_q, last_d;
  logic [4:0]      tap_q, tap_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic [1:0]      ack_q, ack_d;
  logic            mac_en_q, mac_en_d;
  logic            acc_clr_q, acc_clr_d;
  logic            out_valid_q, out_valid_d;
  logic            out_ch_q, out_ch_d;

  // State and registered outputs. last_q resets to 1 so ch0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ch_sel_q    <= 1'b0;
      last_q      <= 1'b1;
      tap_q       <= 5'd0;
      drain_q     <= '0;
      ack_q       <= 2'b00;
      mac_en_q    <= 1'b0;
      acc_clr_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_sel_q    <= ch_sel_d;
      last_q      <= last_d;
      tap_q       <= tap_d;
      drain_q     <= drain_d;
      ack_q       <= ack_d;
      mac_en_q    <= mac_en_d;
      acc_clr_q   <= acc_clr_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
    end
  end

  // Next-state logic, arbitration and tap/drain sequencing.
  always_comb begin
    state_d  = state_q;
    ch_sel_d = ch_sel_q;
    last_d   = last_q;
    tap_d    = tap_q;
    drain_d  = drain_q;
    case (state_q)
      IDLE: begin
        tap_d = 5'd0;
        if (req != 2'b00) begin
          state_d = LOAD;
          // On a tie the channel not granted last wins; otherwise the lone requester.
          ch_sel_d = (req == 2'b11) ? ~last_q : req[1];
        end
      end
      LOAD: begin
        state_d = RUN;
        tap_d   = 5'd0;
      end
      RUN: begin
        if (tap_q == TAP_LAST) begin
          state_d = FLUSH;
          drain_d = '0;
        end else begin
          tap_d = tap_q + 5'd1;
        end
      end
      FLUSH: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = DONE;
          tap_d   = 5'd0;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        last_d  = ch_sel_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    ack_d       = 2'b00;
    acc_clr_d   = 1'b0;
    mac_en_d    = 1'b0;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    case (state_d)
      LOAD: begin
        ack_d     = ch_sel_d ? 2'b10 : 2'b01;
        acc_clr_d = 1'b1;
      end
      RUN:  mac_en_d = 1'b1;
      DONE: begin
        out_valid_d = 1'b1;
        out_ch_d    = ch_sel_q;
      end
      default: ;
    endcase
  end

  assign ack       = ack_q;
  assign ch_sel    = ch_sel_q;
  assign tap_addr  = tap_q;
  assign mac_en    = mac_en_q;
  assign acc_clr   = acc_clr_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign busy      = (state_q != IDLE);

`ifdef SCHED_STATS_EN
  logic [15:0] busy_cnt_q, busy_cnt_d;

  // Saturating busy-cycle counter; a clear request overrides counting.
  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (stat_clr)
      busy_cnt_d = 16'd0;
    else if (busy && (busy_cnt_q != 16'hFFFF))
      busy_cnt_d = busy_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_cnt_q <= 16'd0;
    else      busy_cnt_q <= busy_cnt_d;
  end

  assign busy_cnt = busy_cnt_q;
`endif

endmodule
